// File: rtl/instr_fetch_pkg.sv
// Shared core types: datapath width, instruction-fetch FSM states and the
// control FSM state set that drives fetch_start.
package instr_fetch_pkg;

  localparam int XLEN = 32;

  // Instruction fetch unit states
  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_WAIT  = 2'd1,
    FS_VALID = 2'd2
  } fetch_state_t;

  // Control FSM states of the core; FETCH is the one that raises fetch_start
  typedef enum logic [2:0] {
    CS_FETCH     = 3'd0,
    CS_DECODE    = 3'd1,
    CS_EXECUTE   = 3'd2,
    CS_MEMORY    = 3'd3,
    CS_WRITEBACK = 3'd4
  } ctrl_state_t;

  // Instruction addresses must be word aligned
  function automatic logic word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one memory read per fetch_start, holds the
// returned word with its address, tracks wait cycles and rejects misaligned PCs.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic            pc_update,
  input  logic [XLEN-1:0] pc_next,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_plus4,
  output logic            busy,
  output logic            misaligned,
  output logic [15:0]     stall_count
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic            upd_ok;       // pc_update carrying an acceptable target
  logic            upd_bad;      // pc_update carrying a misaligned target
  logic [XLEN-1:0] fetch_pc;     // address used when a fetch is launched
  logic            pend_valid;   // a PC update arrived while waiting
  logic [XLEN-1:0] pend_pc;

  assign upd_ok   = pc_update && word_aligned(pc_next);
  assign upd_bad  = pc_update && !word_aligned(pc_next);
  assign fetch_pc = upd_ok ? pc_next : pc_cur;
  assign pc_plus4 = pc_cur + XLEN'(4);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; requests arriving outside IDLE are dropped, not queued
  always_comb begin
    state_next = state;
    unique case (state)
      FS_IDLE:  if (fetch_start) state_next = FS_WAIT;
      FS_WAIT:  if (mem_ready) state_next = FS_VALID;
      FS_VALID: state_next = FS_IDLE;
      default:  state_next = FS_IDLE;
    endcase
  end

  // State-decoded outputs; mem_req drops as soon as reset forces IDLE
  always_comb begin
    mem_req     = (state == FS_WAIT);
    busy        = (state == FS_WAIT);
    instr_valid = (state == FS_VALID);
  end

  // Request address is latched at launch and stays put for the whole wait
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr <= RESET_PC;
    end else if (state == FS_IDLE && fetch_start) begin
      mem_addr <= fetch_pc;
    end
  end

  // Program counter; updates seen while waiting are deferred to the capture edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_cur <= RESET_PC;
    end else begin
      unique case (state)
        FS_IDLE:  if (fetch_start || upd_ok) pc_cur <= fetch_pc;
        FS_WAIT: begin
          if (mem_ready) begin
            if (upd_ok) begin
              pc_cur <= pc_next;
            end else if (pend_valid) begin
              pc_cur <= pend_pc;
            end
          end
        end
        FS_VALID: if (upd_ok) pc_cur <= pc_next;
        default:  pc_cur <= pc_cur;
      endcase
    end
  end

  // Single-entry pending PC slot, newest update overwrites older ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else if (state == FS_WAIT) begin
      if (mem_ready) begin
        pend_valid <= 1'b0;
      end else if (upd_ok) begin
        pend_valid <= 1'b1;
        pend_pc    <= pc_next;
      end
    end
  end

  // Instruction capture on the cycle memory answers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= '0;
    end else if (state == FS_WAIT && mem_ready) begin
      instr <= mem_rdata;
    end
  end

  // Sticky misalignment flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misaligned <= 1'b0;
    end else if (upd_bad) begin
      misaligned <= 1'b1;
    end
  end

  // Saturating count of cycles spent waiting for memory
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (state == FS_WAIT && !mem_ready && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port fetch_start, input, 1 bit: request one instruction fetch (from control FSM FETCH state).
REQ-005 SHALL have port pc_update, input, 1 bit: load pc_next into the PC.
REQ-006 SHALL have port pc_next, input, 32 bits: next PC (pc_plus4, branch or jump target).
REQ-007 SHALL have port mem_req, output, 1 bit: memory read request.
REQ-008 SHALL have port mem_addr, output, 32 bits: byte address of the request.
REQ-009 SHALL have port mem_ready, input, 1 bit: mem_rdata valid this cycle.
REQ-010 SHALL have port mem_rdata, input, 32 bits: instruction word from memory.
REQ-011 SHALL have port instr, output, 32 bits: last fetched instruction, held until the next capture.
REQ-012 SHALL have port instr_valid, output, 1 bit: one-cycle pulse when instr is newly captured.
REQ-013 SHALL have port pc_cur, output, 32 bits: address of instr.
REQ-014 SHALL have port pc_plus4, output, 32 bits: pc_cur + 4, modulo 2^32.
REQ-015 SHALL have port busy, output, 1 bit: high while a request is outstanding.
REQ-016 SHALL have port misaligned, output, 1 bit: sticky flag for a rejected PC.
REQ-017 SHALL have port stall_count, output, 16 bits: saturating count of cycles spent waiting on memory.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT and VALID.
REQ-019 IDLE with fetch_start=1 SHALL move to WAIT at the next edge and register mem_addr = (pc_update ? pc_next : pc_cur); pc_cur SHALL take the same value.
REQ-020 In WAIT, mem_req SHALL be 1 and mem_addr SHALL be stable; mem_req SHALL be 0 in every other state.
REQ-021 WAIT with mem_ready=1 SHALL capture mem_rdata into instr and move to VALID; minimum fetch_start-to-instr_valid latency SHALL be 2 cycles.
REQ-022 WAIT with mem_ready=0 SHALL remain in WAIT with no timeout, and stall_count SHALL increment, saturating at 16'hFFFF.
REQ-023 VALID SHALL assert instr_valid for exactly one cycle and return to IDLE; fetch_start in VALID SHALL be ignored.
REQ-024 busy SHALL equal (state == WAIT).
REQ-025 pc_update in IDLE or VALID SHALL load pc_next into pc_cur at the next edge.
REQ-026 pc_update during WAIT SHALL be buffered: one pending slot, last write wins, applied on the WAIT->VALID edge (pc_cur keeps its value until then).
REQ-027 pc_next with pc_next[1:0] != 0 on a pc_update SHALL be rejected: pc_cur unchanged and misaligned set; misaligned SHALL clear only on reset.
REQ-028 fetch_start while in WAIT SHALL be ignored; requests SHALL NOT queue.
REQ-029 pc_plus4 SHALL wrap: pc_cur = 32'hFFFF_FFFC gives pc_plus4 = 0.

Reset
REQ-030 reset=0 SHALL, asynchronously and independent of clk, force: state=IDLE, pc_cur=RESET_PC, mem_req=0, mem_addr=RESET_PC, instr=0, instr_valid=0, busy=0, misaligned=0, stall_count=0, pending update cleared.
REQ-031 Reset asserted in WAIT SHALL abandon the request; a mem_ready arriving afterwards SHALL be ignored.
REQ-032 After reset deasserts, the first fetch_start SHALL fetch from RESET_PC.

Structure
REQ-033 The state enum type and the XLEN=32 constant SHALL reside in the core's shared types package, alongside the control FSM state definitions.
REQ-034 The block SHALL be a single module with no sub-modules; the stall counter and pending-PC buffer SHALL be inline.

Verification
REQ-035 Reset, then fetch_start with mem_ready=1 on the first WAIT cycle and mem_rdata=32'h00115093 -> mem_addr=0; instr_valid one cycle, 2 cycles after fetch_start; instr=32'h00115093; pc_plus4=4.
REQ-036 Fetch with mem_ready held low for 3 cycles -> busy high for 4 cycles; stall_count=3; instr captured on the 4th WAIT cycle.
REQ-037 pc_update with pc_next=8 during WAIT -> pc_cur stays 0 until VALID, then 8; the next fetch uses mem_addr=8.
REQ-038 pc_update with pc_next=32'h6 -> misaligned=1, pc_cur unchanged, flag persists until reset.
REQ-039 Drive reset=0 mid-WAIT, between clock edges -> mem_req falls immediately; a later mem_ready produces no instr_valid; the next fetch address is RESET_PC.
REQ-040 Load pc_cur=32'hFFFF_FFFC -> pc_plus4=0; 70000 stall cycles -> stall_count=16'hFFFF.
